// File: rtl/dpwm_softstart_seq_pkg.sv
// Shared state encoding and width defaults for the DPWM soft-start sequencer.
package dpwm_softstart_seq_pkg;

  localparam int DUTY_W_DEF = 10;
  localparam int FREQ_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    FREQ_DN,
    FREQ_UP,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/dpwm_ramp_step.sv
// Combinational saturating step: moves duty toward goal by STEP without overshoot.
module dpwm_ramp_step #(
  parameter int DUTY_W = 10,
  parameter int STEP   = 8
) (
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] goal,
  output logic [DUTY_W-1:0] next_duty
);

  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(STEP);

  logic          up;
  logic [DUTY_W:0] diff;

  // The distance is taken one bit wider so the comparison against STEP cannot wrap.
  always_comb begin
    up   = (goal > duty);
    diff = up ? ({1'b0, goal} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, goal});
    if (diff < STEP_X) begin
      next_duty = goal;
    end else if (up) begin
      next_duty = duty + STEP_N;
    end else begin
      next_duty = duty - STEP_N;
    end
  end

endmodule

// File: rtl/dpwm_softstart_seq.sv
// Soft-start sequencer: accepts duty/frequency targets and ramps them glitch-free
// onto the DPWM datapath on PWM period boundaries, with a latched fault shutdown.
module dpwm_softstart_seq
  import dpwm_softstart_seq_pkg::*;
#(
  parameter int DUTY_W         = DUTY_W_DEF,
  parameter int FREQ_W         = FREQ_W_DEF,
  parameter int STEP           = 8,
  parameter int TICKS_PER_STEP = 4,
  parameter int DUTY_MAX       = 1000
) (
  input  logic              clkm,
  input  logic              reset,
  input  logic              enable,
  input  logic              period_tick,
  input  logic              req_valid,
  input  logic [DUTY_W-1:0] req_duty,
  input  logic [FREQ_W-1:0] req_freq,
  output logic              req_ready,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] duty_cmd,
  output logic [FREQ_W-1:0] freq_cmd,
  output logic              busy,
  output logic              fault_flag
);

  localparam int               CNT_W    = $clog2(TICKS_PER_STEP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [DUTY_W-1:0] DUTY_LIM = DUTY_W'(DUTY_MAX);

  seq_state_t        state, state_n;
  logic [CNT_W-1:0]  tick_cnt, tick_cnt_n;
  logic [DUTY_W-1:0] duty_n, tgt_duty, tgt_duty_n, goal, stepped, req_duty_lim;
  logic [FREQ_W-1:0] freq_n, tgt_freq, tgt_freq_n;
  logic              xfer, step_evt;

  assign req_ready    = (state == IDLE) || (state == HOLD);
  assign busy         = (state == RAMP) || (state == FREQ_DN) || (state == FREQ_UP);
  assign fault_flag   = (state == FAULT);
  assign xfer         = req_valid && req_ready;
  assign step_evt     = period_tick && (tick_cnt == CNT_LAST);
  assign req_duty_lim = (req_duty > DUTY_LIM) ? DUTY_LIM : req_duty;
  // Dropping enable retargets any ramp to zero; a frequency switch always empties first.
  assign goal         = ((state == FREQ_DN) || !enable) ? '0 : tgt_duty;

  dpwm_ramp_step #(
    .DUTY_W(DUTY_W),
    .STEP  (STEP)
  ) u_step (
    .duty     (duty_cmd),
    .goal     (goal),
    .next_duty(stepped)
  );

  always_comb begin
    state_n    = state;
    duty_n     = duty_cmd;
    freq_n     = freq_cmd;
    tgt_duty_n = tgt_duty;
    tgt_freq_n = tgt_freq;
    if (fault) begin
      state_n = FAULT;
      duty_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          duty_n = '0;
          if (xfer && enable) begin
            tgt_duty_n = req_duty_lim;
            tgt_freq_n = req_freq;
            freq_n     = req_freq;
            state_n    = RAMP;
          end
        end
        RAMP, HOLD, FREQ_UP: begin
          if ((state == HOLD) && xfer && enable) begin
            tgt_duty_n = req_duty_lim;
            tgt_freq_n = req_freq;
            state_n    = (req_freq == freq_cmd) ? RAMP : FREQ_DN;
          end else if (duty_cmd == goal) begin
            state_n = enable ? HOLD : IDLE;
          end else if (step_evt) begin
            duty_n = stepped;
            if (stepped == goal) begin
              state_n = enable ? HOLD : IDLE;
            end
          end
        end
        FREQ_DN: begin
          if (duty_cmd == '0) begin
            freq_n  = tgt_freq;
            state_n = enable ? FREQ_UP : IDLE;
          end else if (step_evt) begin
            duty_n = stepped;
          end
        end
        FAULT: begin
          duty_n = '0;
          if (fault_clr) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Every state change restarts the period count so each phase gets full-length steps.
  always_comb begin
    if (state_n != state) begin
      tick_cnt_n = '0;
    end else if (period_tick) begin
      tick_cnt_n = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
    end else begin
      tick_cnt_n = tick_cnt;
    end
  end

  always_ff @(posedge clkm or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      duty_cmd <= '0;
      freq_cmd <= '0;
      tgt_duty <= '0;
      tgt_freq <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      duty_cmd <= duty_n;
      freq_cmd <= freq_n;
      tgt_duty <= tgt_duty_n;
      tgt_freq <= tgt_freq_n;
    end
  end

endmodule

// File: tb/tb_dpwm_softstart_seq.sv
// Randomized self-checking bench for dpwm_softstart_seq: expected ramps are built
// arithmetically from start/goal values and compared with observed duty changes.
`timescale 1ns/1ps
module tb_dpwm_softstart_seq;

  localparam int STEP = 8;
  localparam int TPS  = 4;
  localparam int DMAX = 1000;

  logic       clkm = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       period_tick = 1'b0;
  logic       req_valid = 1'b0;
  logic [9:0] req_duty = '0;
  logic [2:0] req_freq = '0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       req_ready, busy, fault_flag;
  logic [9:0] duty_cmd;
  logic [2:0] freq_cmd;

  int checks = 0;
  int failures = 0;
  int cur_duty = 0;
  int cur_freq = 0;
  int exp_q[$];
  int obs_val[$];
  int obs_tick[$];
  bit obs_on[$];
  bit ready_seen;

  always #5 clkm = ~clkm;

  dpwm_softstart_seq #(
    .DUTY_W(10), .FREQ_W(3), .STEP(STEP), .TICKS_PER_STEP(TPS), .DUTY_MAX(DMAX)
  ) dut (
    .clkm(clkm), .reset(reset), .enable(enable), .period_tick(period_tick),
    .req_valid(req_valid), .req_duty(req_duty), .req_freq(req_freq), .req_ready(req_ready),
    .fault(fault), .fault_clr(fault_clr), .duty_cmd(duty_cmd), .freq_cmd(freq_cmd),
    .busy(busy), .fault_flag(fault_flag)
  );

  // Expected duty sequence: one entry per step, STEP LSBs at a time, landing exactly on goal.
  task automatic build_ramp(input int from, input int goal);
    int v;
    v = from;
    exp_q.delete();
    while (v != goal) begin
      if (goal > v) v = ((goal - v) < STEP) ? goal : v + STEP;
      else          v = ((v - goal) < STEP) ? goal : v - STEP;
      exp_q.push_back(v);
    end
  endtask

  // Drives random period ticks from a negedge and records every duty change seen.
  task automatic observe(input int nchg, input int max_cycles);
    int ticks;
    int cyc;
    int prev;
    bit tk;
    ticks = 0;
    cyc = 0;
    prev = int'(duty_cmd);
    obs_val.delete(); obs_tick.delete(); obs_on.delete();
    ready_seen = 1'b0;
    while (cyc < max_cycles && (nchg == 0 || obs_val.size() < nchg)) begin
      tk = ($urandom_range(0, 2) == 0);
      period_tick = tk;
      if (tk) ticks++;
      @(negedge clkm);
      cyc++;
      if (int'(duty_cmd) != prev) begin
        prev = int'(duty_cmd);
        obs_val.push_back(prev);
        obs_tick.push_back(ticks);
        obs_on.push_back(tk);
      end
      if (req_ready && obs_val.size() < nchg) ready_seen = 1'b1;
    end
    period_tick = 1'b0;
  endtask

  function automatic int budget(input int n);
    return (n + 1) * TPS * 20 + 20;
  endfunction

  task automatic transfer(input int duty, input int freq, input bit with_tick);
    req_valid = 1'b1;
    req_duty = 10'(duty);
    req_freq = 3'(freq);
    period_tick = with_tick;
    @(negedge clkm);
    req_valid = 1'b0;
    period_tick = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (duty_cmd !== 10'd0 || freq_cmd !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_cmds: got duty=%0d freq=%0d expected duty=0 freq=0", duty_cmd, freq_cmd);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || fault_flag !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got ready=%b busy=%b fault_flag=%b expected 1 0 0", req_ready, busy, fault_flag);
    end
    @(negedge clkm);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clkm);
  endtask

  task automatic test_first_ramp();
    transfer(100, 2, 1'b0);
    checks++;
    if (freq_cmd !== 3'd2 || busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_accept: got freq=%0d busy=%b ready=%b expected freq=2 busy=1 ready=0", freq_cmd, busy, req_ready);
    end
    build_ramp(0, 100);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL first_count: got %0d steps expected %0d", obs_val.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL first_step%0d: got duty=%0d tick=%0d on_tick=%0d expected duty=%0d tick=%0d on_tick=1",
                 i, obs_val[i], obs_tick[i], obs_on[i], exp_q[i], (i + 1) * TPS);
      end
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || ready_seen) begin
      failures++;
      $display("[TB] FAIL first_hold: got busy=%b ready=%b ready_during_ramp=%0d expected 0 1 0", busy, req_ready, ready_seen);
    end
    cur_duty = 100;
    cur_freq = 2;
  endtask

  task automatic test_ramp_down();
    transfer(50, 2, 1'b0);
    build_ramp(100, 50);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL down_count: got %0d steps expected %0d", obs_val.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL down_step%0d: got duty=%0d tick=%0d on_tick=%0d expected duty=%0d tick=%0d on_tick=1",
                 i, obs_val[i], obs_tick[i], obs_on[i], exp_q[i], (i + 1) * TPS);
      end
    end
    checks++;
    if (freq_cmd !== 3'd2 || busy !== 1'b0 || req_ready !== 1'b1 || ready_seen) begin
      failures++;
      $display("[TB] FAIL down_end: got freq=%0d busy=%b ready=%b ready_during_ramp=%0d expected 2 0 1 0",
               freq_cmd, busy, req_ready, ready_seen);
    end
    cur_duty = 50;
  endtask

  task automatic test_freq_change();
    transfer(100, 5, 1'b0);
    build_ramp(50, 0);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size() || freq_cmd !== 3'd2) begin
      failures++;
      $display("[TB] FAIL fdn_phase: got %0d steps freq=%0d expected %0d steps freq=2", obs_val.size(), freq_cmd, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL fdn_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                 i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
      end
    end
    @(negedge clkm);
    checks++;
    if (freq_cmd !== 3'd5 || duty_cmd !== 10'd0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fswitch: got freq=%0d duty=%0d busy=%b expected freq=5 duty=0 busy=1", freq_cmd, duty_cmd, busy);
    end
    build_ramp(0, 100);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL fup_count: got %0d steps expected %0d", obs_val.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL fup_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                 i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
      end
    end
    checks++;
    if (busy !== 1'b0 || freq_cmd !== 3'd5) begin
      failures++;
      $display("[TB] FAIL fup_end: got busy=%b freq=%0d expected busy=0 freq=5", busy, freq_cmd);
    end
    cur_duty = 100;
    cur_freq = 5;
  endtask

  // A period tick coincident with the transfer must not count toward the first step.
  task automatic test_back_to_back();
    transfer(60, 5, 1'b1);
    build_ramp(100, 60);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d steps expected %0d", obs_val.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL b2b_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                 i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
      end
    end
    cur_duty = 60;
  endtask

  task automatic test_clamp();
    int peak;
    transfer(1023, 5, 1'b0);
    build_ramp(60, DMAX);
    observe(exp_q.size(), budget(exp_q.size()));
    peak = 0;
    foreach (obs_val[i]) if (obs_val[i] > peak) peak = obs_val[i];
    checks++;
    if (obs_val.size() != exp_q.size() || peak > DMAX || duty_cmd !== 10'(DMAX)) begin
      failures++;
      $display("[TB] FAIL clamp: got %0d steps peak=%0d final=%0d expected %0d steps peak<=%0d final=%0d",
               obs_val.size(), peak, duty_cmd, exp_q.size(), DMAX, DMAX);
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS) begin
        failures++;
        $display("[TB] FAIL clamp_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                 i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
      end
    end
    cur_duty = DMAX;
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int d;
      int dc;
      int f;
      d = $urandom_range(0, 1023);
      dc = (d > DMAX) ? DMAX : d;
      if (dc == 20) dc = 21;
      if (d != 1023 && d > DMAX) d = dc;
      if (d <= DMAX) d = dc;
      f = cur_freq;
      if ($urandom_range(0, 2) == 0) f = (cur_freq + $urandom_range(1, 7)) % 8;
      transfer(d, f, 1'b0);
      if (f != cur_freq) begin
        build_ramp(cur_duty, 0);
        if (exp_q.size() > 0) observe(exp_q.size(), budget(exp_q.size()));
        else obs_val.delete();
        checks++;
        if (obs_val.size() != exp_q.size() || int'(freq_cmd) != cur_freq) begin
          failures++;
          $display("[TB] FAIL rnd%0d_dn: got %0d steps freq=%0d expected %0d steps freq=%0d",
                   it, obs_val.size(), freq_cmd, exp_q.size(), cur_freq);
        end
        foreach (exp_q[i]) if (i < obs_val.size()) begin
          checks++;
          if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS) begin
            failures++;
            $display("[TB] FAIL rnd%0d_dn_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                     it, i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
          end
        end
        @(negedge clkm);
        checks++;
        if (int'(freq_cmd) != f) begin
          failures++;
          $display("[TB] FAIL rnd%0d_fswitch: got freq=%0d expected %0d", it, freq_cmd, f);
        end
        cur_duty = 0;
      end
      build_ramp(cur_duty, dc);
      observe(exp_q.size(), (exp_q.size() == 0) ? 20 : budget(exp_q.size()));
      checks++;
      if (obs_val.size() != exp_q.size()) begin
        failures++;
        $display("[TB] FAIL rnd%0d_count: got %0d steps expected %0d", it, obs_val.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_val.size()) begin
        checks++;
        if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
          failures++;
          $display("[TB] FAIL rnd%0d_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                   it, i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
        end
      end
      @(negedge clkm);
      checks++;
      if (int'(duty_cmd) != dc || busy !== 1'b0 || int'(freq_cmd) != f) begin
        failures++;
        $display("[TB] FAIL rnd%0d_end: got duty=%0d busy=%b freq=%0d expected duty=%0d busy=0 freq=%0d",
                 it, duty_cmd, busy, freq_cmd, dc, f);
      end
      cur_duty = dc;
      cur_freq = f;
    end
  endtask

  task automatic test_enable_off();
    transfer(20, cur_freq, 1'b0);
    build_ramp(cur_duty, 20);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (duty_cmd !== 10'd20) begin
      failures++;
      $display("[TB] FAIL en_setup: got duty=%0d expected 20", duty_cmd);
    end
    enable = 1'b0;
    build_ramp(20, 0);
    observe(exp_q.size(), budget(exp_q.size()));
    checks++;
    if (obs_val.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL en_count: got %0d steps expected %0d", obs_val.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_val.size()) begin
      checks++;
      if (obs_val[i] != exp_q[i] || obs_tick[i] != (i + 1) * TPS || !obs_on[i]) begin
        failures++;
        $display("[TB] FAIL en_step%0d: got duty=%0d tick=%0d expected duty=%0d tick=%0d",
                 i, obs_val[i], obs_tick[i], exp_q[i], (i + 1) * TPS);
      end
    end
    @(negedge clkm);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || duty_cmd !== 10'd0) begin
      failures++;
      $display("[TB] FAIL en_idle: got ready=%b busy=%b duty=%0d expected 1 0 0", req_ready, busy, duty_cmd);
    end
    enable = 1'b1;
    cur_duty = 0;
  endtask

  task automatic test_fault();
    int newf;
    newf = (cur_freq == 5) ? 6 : 5;
    transfer(200, newf, 1'b0);
    checks++;
    if (int'(freq_cmd) != newf) begin
      failures++;
      $display("[TB] FAIL fault_idle_freq: got freq=%0d expected %0d", freq_cmd, newf);
    end
    build_ramp(0, 200);
    observe(5, budget(5));
    checks++;
    if (obs_val.size() != 5 || duty_cmd !== 10'd40) begin
      failures++;
      $display("[TB] FAIL fault_setup: got %0d steps duty=%0d expected 5 steps duty=40", obs_val.size(), duty_cmd);
    end
    fault = 1'b1;
    @(negedge clkm);
    checks++;
    if (duty_cmd !== 10'd0 || fault_flag !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b0 || int'(freq_cmd) != newf) begin
      failures++;
      $display("[TB] FAIL fault_entry: got duty=%0d flag=%b ready=%b busy=%b freq=%0d expected 0 1 0 0 %0d",
               duty_cmd, fault_flag, req_ready, busy, freq_cmd, newf);
    end
    fault_clr = 1'b1;
    @(negedge clkm);
    fault_clr = 1'b0;
    checks++;
    if (fault_flag !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fault_clr_held: got flag=%b expected 1", fault_flag);
    end
    fault = 1'b0;
    repeat (2) @(negedge clkm);
    checks++;
    if (fault_flag !== 1'b1 || duty_cmd !== 10'd0) begin
      failures++;
      $display("[TB] FAIL fault_latched: got flag=%b duty=%0d expected 1 0", fault_flag, duty_cmd);
    end
    fault_clr = 1'b1;
    @(negedge clkm);
    fault_clr = 1'b0;
    checks++;
    if (fault_flag !== 1'b0 || req_ready !== 1'b1 || duty_cmd !== 10'd0 || int'(freq_cmd) != newf) begin
      failures++;
      $display("[TB] FAIL fault_exit: got flag=%b ready=%b duty=%0d freq=%0d expected 0 1 0 %0d",
               fault_flag, req_ready, duty_cmd, freq_cmd, newf);
    end
    cur_duty = 0;
    cur_freq = newf;
  endtask

  task automatic test_async_reset();
    transfer(300, cur_freq, 1'b0);
    observe(3, budget(3));
    checks++;
    if (duty_cmd !== 10'd24) begin
      failures++;
      $display("[TB] FAIL areset_setup: got duty=%0d expected 24", duty_cmd);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (duty_cmd !== 10'd0 || freq_cmd !== 3'd0 || fault_flag !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset: got duty=%0d freq=%0d flag=%b ready=%b expected 0 0 0 1",
               duty_cmd, freq_cmd, fault_flag, req_ready);
    end
    @(negedge clkm);
    reset = 1'b1;
    @(negedge clkm);
  endtask

  initial begin
    test_reset();
    test_first_ramp();
    test_ramp_down();
    test_freq_change();
    test_back_to_back();
    test_clamp();
    test_random();
    test_enable_off();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
